// File: rtl/jt51_wrqueue.sv
// jt51_wrqueue: host write FIFO feeding the jt51 bus pins.
// Replays each (addr,data) pair on cen_p1 and waits out the busy flag.
module jt51_wrqueue #(
    parameter int DEPTH   = 16,
    parameter int GUARD   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cen_p1,
    input  logic                     push,
    input  logic [7:0]               push_addr,
    input  logic [7:0]               push_data,
    input  logic                     flush,
    input  logic                     clr_err,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     timeout,
    output logic                     idle,
    output logic                     ym_cs_n,
    output logic                     ym_wr_n,
    output logic                     ym_a0,
    output logic [7:0]               ym_din,
    input  logic [7:0]               ym_dout
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [7:0] GUARD_LAST = 8'(GUARD - 1);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_WR,
        S_ADDR_GAP,
        S_DATA_WR,
        S_GUARD,
        S_BUSY
    } state_t;

    state_t         state, state_n;
    logic [15:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [LW-1:0]  lvl_n;
    logic [7:0]     cnt, cnt_n;
    logic [7:0]     cur_data;
    logic [15:0]    head;
    logic           push_ok, pop, ovf_set, tmo_set;
    logic           cs_n_d, a0_d;
    logic [7:0]     din_d;
    logic           unused_dout;

    assign unused_dout = ^ym_dout[6:0];
    assign head        = mem[rd_ptr];
    assign push_ok     = push && !full && !flush;
    assign ovf_set     = push && full && !flush;

    // FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= {push_addr, push_data};
    end

    // next pointers and fill level
    always_comb begin
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        lvl_n    = level;
        if (flush) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            lvl_n    = '0;
        end else begin
            if (push_ok) wr_ptr_n = wr_ptr + AW'(1);
            if (pop)     rd_ptr_n = rd_ptr + AW'(1);
            lvl_n = level + LW'(push_ok) - LW'(pop);
        end
    end

    // state register and sequencer datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            cur_data <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (pop) cur_data <= head[7:0];
        end
    end

    // next-state logic; every advance past IDLE waits for cen_p1
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pop     = 1'b0;
        tmo_set = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = S_ADDR_WR;
                end
            end
            S_ADDR_WR: begin
                if (cen_p1) state_n = S_ADDR_GAP;
            end
            S_ADDR_GAP: begin
                if (cen_p1) state_n = S_DATA_WR;
            end
            S_DATA_WR: begin
                if (cen_p1) begin
                    state_n = S_GUARD;
                    cnt_n   = '0;
                end
            end
            S_GUARD: begin
                if (cen_p1) begin
                    if (cnt == GUARD_LAST) begin
                        cnt_n   = '0;
                        state_n = S_BUSY;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
            end
            S_BUSY: begin
                if (cen_p1) begin
                    if (!ym_dout[7]) begin
                        state_n = S_IDLE;
                    end else if (cnt + 8'd1 == TMO_LAST) begin
                        cnt_n   = '0;
                        tmo_set = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        cnt_n = cnt + 8'd1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // bus values for the next cycle; a0/din only move while strobes are high
    always_comb begin
        cs_n_d = !(state_n == S_ADDR_WR || state_n == S_DATA_WR);
        a0_d   = ym_a0;
        din_d  = ym_din;
        if (pop) begin
            a0_d  = 1'b0;
            din_d = head[15:8];
        end else if (state == S_ADDR_GAP && cen_p1) begin
            a0_d  = 1'b1;
            din_d = cur_data;
        end
    end

    // registered FIFO state, flags and chip pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            idle     <= 1'b1;
            overflow <= 1'b0;
            timeout  <= 1'b0;
            ym_cs_n  <= 1'b1;
            ym_wr_n  <= 1'b1;
            ym_a0    <= 1'b0;
            ym_din   <= '0;
        end else begin
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            level    <= lvl_n;
            full     <= (lvl_n == LW'(DEPTH));
            empty    <= (lvl_n == '0);
            idle     <= (state_n == S_IDLE) && (lvl_n == '0);
            overflow <= ovf_set | (overflow & ~clr_err);
            timeout  <= tmo_set | (timeout & ~clr_err);
            ym_cs_n  <= cs_n_d;
            ym_wr_n  <= cs_n_d;
            ym_a0    <= a0_d;
            ym_din   <= din_d;
        end
    end

endmodule
